// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the handshake pipeline stage register.
package pipe_stage_reg_pkg;

  // Occupancy-encoded states: the encoding doubles as the held-entry count.
  typedef enum logic [1:0] {
    PsEmpty = 2'd0,
    PsOne   = 2'd1,
    PsTwo   = 2'd2
  } ps_state_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with increment enable and synchronous clear.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // Clear wins over increment; hold once all ones.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// bubble payload substitution and a saturating bubble counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned     DATA_W     = 32,
  parameter bit              SKID       = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  ps_state_e         state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire;

  // Without the skid entry, ready is the classic combinational pass-through.
  assign in_ready = SKID ? in_ready_q : (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Next-state: handshake moves, then flush overrides everything.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      PsEmpty: begin
        if (in_fire) begin
          head_d      = in_data;
          out_valid_d = 1'b1;
          state_d     = PsOne;
        end
      end
      PsOne: begin
        if (in_fire && out_fire) begin
          head_d = in_data;
        end else if (in_fire && SKID) begin
          // Head is stalled; park the new payload behind it.
          skid_d  = in_data;
          state_d = PsTwo;
        end else if (out_fire) begin
          head_d      = BUBBLE_VAL;
          out_valid_d = 1'b0;
          state_d     = PsEmpty;
        end
      end
      PsTwo: begin
        if (out_fire) begin
          head_d  = skid_q;
          state_d = PsOne;
        end
      end
      default: begin
        head_d      = BUBBLE_VAL;
        out_valid_d = 1'b0;
        state_d     = PsEmpty;
      end
    endcase

    if (flush) begin
      head_d      = BUBBLE_VAL;
      out_valid_d = 1'b0;
      state_d     = PsEmpty;
    end

    // Registered ready looks one state ahead so TWO never accepts.
    in_ready_d = (state_d != PsTwo);
  end

  // Stage state registers with synchronous reset.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q     <= PsEmpty;
      head_q      <= BUBBLE_VAL;
      skid_q      <= BUBBLE_VAL;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = head_q;
  assign occupancy = state_q;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_bubble_cnt (
    .clk_i   (cpu_clk_50M),
    .clr_i   (cpu_rst),
    .en_i    (!out_valid_q),
    .count_o (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: DUT a uses the skid buffer, DUT b is single-entry with a
// non-zero bubble word and a 4-bit bubble counter.
module tb_pipe_stage_reg;

  logic cpu_clk_50M;

  logic        rst_a, flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [31:0] in_data_a, out_data_a;
  logic [1:0]  occ_a;
  logic [15:0] bcnt_a;

  logic        rst_b, flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [31:0] in_data_b, out_data_b;
  logic [1:0]  occ_b;
  logic [3:0]  bcnt_b;

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;

  pipe_stage_reg #(
    .DATA_W     (32),
    .SKID       (1'b1),
    .BUBBLE_VAL (32'h0000_0000),
    .CNT_W      (16)
  ) u_dut_a (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (rst_a),
    .flush       (flush_a),
    .in_valid    (in_valid_a),
    .in_ready    (in_ready_a),
    .in_data     (in_data_a),
    .out_valid   (out_valid_a),
    .out_ready   (out_ready_a),
    .out_data    (out_data_a),
    .occupancy   (occ_a),
    .bubble_cnt  (bcnt_a)
  );

  pipe_stage_reg #(
    .DATA_W     (32),
    .SKID       (1'b0),
    .BUBBLE_VAL (32'hDEAD_BEEF),
    .CNT_W      (4)
  ) u_dut_b (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (rst_b),
    .flush       (flush_b),
    .in_valid    (in_valid_b),
    .in_ready    (in_ready_b),
    .in_data     (in_data_b),
    .out_valid   (out_valid_b),
    .out_ready   (out_ready_b),
    .out_data    (out_data_b),
    .occupancy   (occ_b),
    .bubble_cnt  (bcnt_b)
  );

  initial cpu_clk_50M = 1'b0;
  always #5 cpu_clk_50M = ~cpu_clk_50M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; flush_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
    rst_b = 1'b1; flush_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;

    // ---- DUT a: reset then idle ----
    tick();
    rst_a = 1'b0;
    check("a_rst_in_ready", 32'(in_ready_a), 32'd0);
    check("a_rst_valid", 32'(out_valid_a), 32'd0);
    tick();
    check("a_in_ready_c2", 32'(in_ready_a), 32'd1);
    repeat (4) tick();
    check("a_idle_valid", 32'(out_valid_a), 32'd0);
    check("a_idle_data", out_data_a, 32'h0);
    check("a_idle_occ", 32'(occ_a), 32'd0);
    check("a_idle_bcnt", 32'(bcnt_a), 32'd5);

    // ---- DUT a: streaming at full rate ----
    out_ready_a = 1'b1; in_valid_a = 1'b1; in_data_a = 32'h11;
    tick();
    check("a_s1", out_data_a, 32'h11);
    check("a_s1_valid", 32'(out_valid_a), 32'd1);
    in_data_a = 32'h22;
    tick();
    check("a_s2", out_data_a, 32'h22);
    in_data_a = 32'h33;
    tick();
    check("a_s3", out_data_a, 32'h33);
    check("a_s3_valid", 32'(out_valid_a), 32'd1);
    in_valid_a = 1'b0;
    tick();
    check("a_s_drain_valid", 32'(out_valid_a), 32'd0);
    check("a_s_drain_data", out_data_a, 32'h0);
    check("a_s_bcnt", 32'(bcnt_a), 32'd6);

    // ---- DUT a: backpressure fills the skid ----
    out_ready_a = 1'b0; in_valid_a = 1'b1; in_data_a = 32'hA1;
    tick();
    in_data_a = 32'hA2;
    tick();
    check("a_bp_occ2", 32'(occ_a), 32'd2);
    check("a_bp_in_ready", 32'(in_ready_a), 32'd0);
    check("a_bp_head", out_data_a, 32'hA1);
    in_data_a = 32'hA3;
    tick();
    tick();
    check("a_bp_hold_occ", 32'(occ_a), 32'd2);
    check("a_bp_hold_head", out_data_a, 32'hA1);
    out_ready_a = 1'b1;
    tick();
    check("a_bp_pop1", out_data_a, 32'hA2);
    check("a_bp_pop1_occ", 32'(occ_a), 32'd1);
    check("a_bp_pop1_ready", 32'(in_ready_a), 32'd1);
    tick();
    check("a_bp_pop2", out_data_a, 32'hA3);
    check("a_bp_pop2_valid", 32'(out_valid_a), 32'd1);
    in_valid_a = 1'b0;
    tick();
    check("a_bp_empty", 32'(out_valid_a), 32'd0);

    // ---- DUT a: flush in TWO with a payload offered ----
    out_ready_a = 1'b0; in_valid_a = 1'b1; in_data_a = 32'hB1;
    tick();
    in_data_a = 32'hB2;
    tick();
    check("a_fl_occ2", 32'(occ_a), 32'd2);
    flush_a = 1'b1; in_data_a = 32'hFF;
    tick();
    flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
    check("a_fl_valid", 32'(out_valid_a), 32'd0);
    check("a_fl_data", out_data_a, 32'h0);
    check("a_fl_occ", 32'(occ_a), 32'd0);
    tick();
    check("a_fl_no_ff", 32'(out_valid_a), 32'd0);
    check("a_fl_no_ff_data", out_data_a, 32'h0);
    check("a_fl_ready", 32'(in_ready_a), 32'd1);

    // ---- DUT a: flush in ONE discards a concurrent in_fire ----
    out_ready_a = 1'b0; in_valid_a = 1'b1; in_data_a = 32'hC1;
    tick();
    check("a_f1_head", out_data_a, 32'hC1);
    flush_a = 1'b1; in_data_a = 32'hC2;
    tick();
    flush_a = 1'b0; in_valid_a = 1'b0;
    check("a_f1_valid", 32'(out_valid_a), 32'd0);
    check("a_f1_occ", 32'(occ_a), 32'd0);
    tick();
    check("a_f1_still_empty", 32'(out_valid_a), 32'd0);

    // ---- DUT b: bubble counter saturation ----
    rst_b = 1'b0;
    repeat (14) tick();
    check("b_bcnt14", 32'(bcnt_b), 32'd14);
    check("b_bubble_data", out_data_b, 32'hDEAD_BEEF);
    repeat (6) tick();
    check("b_bcnt_sat", 32'(bcnt_b), 32'd15);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check("b_bcnt_clr", 32'(bcnt_b), 32'd0);

    // ---- DUT b: SKID=0 combinational ready ----
    in_valid_b = 1'b1; in_data_b = 32'hD1; out_ready_b = 1'b1;
    #1;
    check("b_rdy_empty", 32'(in_ready_b), 32'd1);
    tick();
    check("b_d1", out_data_b, 32'hD1);
    check("b_d1_occ", 32'(occ_b), 32'd1);
    out_ready_b = 1'b0; in_data_b = 32'hD2;
    #1;
    check("b_rdy_stall", 32'(in_ready_b), 32'd0);
    tick();
    check("b_d1_held", out_data_b, 32'hD1);
    out_ready_b = 1'b1;
    #1;
    check("b_rdy_go", 32'(in_ready_b), 32'd1);
    tick();
    check("b_d2", out_data_b, 32'hD2);
    in_valid_b = 1'b0;
    tick();
    check("b_drain_valid", 32'(out_valid_b), 32'd0);
    check("b_drain_data", out_data_b, 32'hDEAD_BEEF);
    check("b_drain_occ", 32'(occ_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
